// File: rtl/wptr_full_ctrl_pkg.sv
// Shared definitions for the async-FIFO pointer blocks: default geometry and
// binary/Gray conversion helpers used by both the write and read pointer logic.
package wptr_full_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_SIZE = 4;
    localparam int unsigned DEFAULT_AF_THRESH = 14;

    // Helpers work on a fixed wide word; callers size-cast to their pointer width.
    localparam int unsigned PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down, done in log2 steps.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Producer-side bundle of the FIFO write-pointer controller; the controller
// is the slave, the producer/memory side is the master.
interface wptr_full_ctrl_if
    import wptr_full_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEFAULT_ADDR_SIZE
);

    logic                 wr_en;
    logic [ADDR_SIZE:0]   rd_ptr_gray;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE:0]   wr_ptr_gray;
    logic                 wr_accept;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_SIZE:0]   wr_count;
    logic                 overflow;

    modport master (
        output wr_en,
        output rd_ptr_gray,
        input  wr_addr,
        input  wr_ptr_gray,
        input  wr_accept,
        input  full,
        input  almost_full,
        input  wr_count,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  rd_ptr_gray,
        output wr_addr,
        output wr_ptr_gray,
        output wr_accept,
        output full,
        output almost_full,
        output wr_count,
        output overflow
    );

endinterface

// File: rtl/wptr_full_ctrl_sync_2ff.sv
// Two-flop clock-domain-crossing synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full and occupancy logic of an async FIFO.
// Flags are computed from the next pointer so they track the write on the same edge.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE          = DEFAULT_ADDR_SIZE,
    parameter int unsigned ALMOST_FULL_THRESH = DEFAULT_AF_THRESH
) (
    input  logic              clk,
    input  logic              rst_n,
    wptr_full_ctrl_if.slave   bus
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    // Full when the Gray pointers differ only in their two MSBs.
    localparam logic [ADDR_SIZE:0] FULL_MASK = PW'(3) << (ADDR_SIZE - 1);
    localparam logic [ADDR_SIZE:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wgray;
    logic [ADDR_SIZE:0] r_count;
    logic               r_full;
    logic               r_afull;
    logic               r_ovf;

    logic               w_accept;
    logic [ADDR_SIZE:0] w_wbin_next;
    logic [ADDR_SIZE:0] w_wgray_next;
    logic [ADDR_SIZE:0] w_rq2;
    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_count_next;
    logic               w_full_next;
    logic               w_afull_next;

    sync_2ff #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.rd_ptr_gray),
        .o_q   (w_rq2)
    );

    always_comb begin
        w_accept     = bus.wr_en & ~r_full;
        w_wbin_next  = r_wbin + PW'(w_accept);
        w_wgray_next = PW'(bin2gray(ptr_word_t'(w_wbin_next)));
        w_rbin       = PW'(gray2bin(ptr_word_t'(w_rq2)));
        w_count_next = w_wbin_next - w_rbin;
        w_full_next  = (w_wgray_next == (w_rq2 ^ FULL_MASK));
        w_afull_next = (w_count_next >= AF_THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_count <= w_count_next;
            r_full  <= w_full_next;
            r_afull <= w_afull_next;
            r_ovf   <= bus.wr_en & r_full;
        end
    end

    assign bus.wr_addr     = r_wbin[ADDR_SIZE-1:0];
    assign bus.wr_ptr_gray = r_wgray;
    assign bus.wr_accept   = w_accept;
    assign bus.full        = r_full;
    assign bus.almost_full = r_afull;
    assign bus.wr_count    = r_count;
    assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed scoreboard bench for wptr_full_ctrl: expectations are queued as each
// step is driven and drained against the DUT once the step has settled.
module tb_wptr_full_ctrl;

    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wptr_full_ctrl_if #(.ADDR_SIZE(AW)) bus ();

    wptr_full_ctrl #(
        .ADDR_SIZE          (AW),
        .ALMOST_FULL_THRESH (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int unsigned {S_ADDR, S_WGRAY, S_ACCEPT, S_FULL, S_AFULL, S_COUNT, S_OVF} sig_e;

    typedef struct {
        string       tag;
        sig_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_ADDR:   return 32'(bus.wr_addr);
            S_WGRAY:  return 32'(bus.wr_ptr_gray);
            S_ACCEPT: return 32'(bus.wr_accept);
            S_FULL:   return 32'(bus.full);
            S_AFULL:  return 32'(bus.almost_full);
            S_COUNT:  return 32'(bus.wr_count);
            S_OVF:    return 32'(bus.overflow);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    function automatic logic [4:0] gray(input int unsigned b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic want(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_vec++;
            assert (obs === e.exp) else begin
                n_miss++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic want_zero(input string tag);
        want({tag, "_addr"},  S_ADDR,   0);
        want({tag, "_wgray"}, S_WGRAY,  0);
        want({tag, "_acc"},   S_ACCEPT, 0);
        want({tag, "_full"},  S_FULL,   0);
        want({tag, "_af"},    S_AFULL,  0);
        want({tag, "_cnt"},   S_COUNT,  0);
        want({tag, "_ovf"},   S_OVF,    0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned w;

        bus.wr_en       = 1'b0;
        bus.rd_ptr_gray = '0;
        rst_n           = 1'b0;

        // Reset state with the clock running
        #12;
        want_zero("rst");
        check_sb();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with the reader parked at 0; almost_full crosses between 13 and 14
        for (int unsigned i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            #1;
            want("fill_addr", S_ADDR, i);
            want("fill_acc", S_ACCEPT, 1);
            check_sb();
            next_edge();
            want("fill_cnt", S_COUNT, i + 1);
            want("fill_full", S_FULL, (i == 15) ? 1 : 0);
            want("fill_af", S_AFULL, (i + 1 >= 14) ? 1 : 0);
            want("fill_wgray", S_WGRAY, 32'(gray(i + 1)));
            want("fill_ovf", S_OVF, 0);
            check_sb();
        end
        want("full_addr", S_ADDR, 0);
        want("full_wgray", S_WGRAY, 32'h18);
        want("full_cnt", S_COUNT, 16);

        // Write attempted while full
        #1;
        want("ovf_acc", S_ACCEPT, 0);
        check_sb();
        next_edge();
        want("ovf_pulse", S_OVF, 1);
        want("ovf_full", S_FULL, 1);
        want("ovf_addr", S_ADDR, 0);
        want("ovf_wgray", S_WGRAY, 32'h18);
        want("ovf_cnt", S_COUNT, 16);
        check_sb();
        bus.wr_en = 1'b0;
        next_edge();
        want("ovf_end", S_OVF, 0);
        want("ovf_hold_addr", S_ADDR, 0);
        want("ovf_hold_wgray", S_WGRAY, 32'h18);
        check_sb();

        // Reader advances to 4: full must survive two edges and drop on the third
        bus.rd_ptr_gray = 5'b00110;
        next_edge();
        want("rel1_full", S_FULL, 1);
        want("rel1_cnt", S_COUNT, 16);
        check_sb();
        next_edge();
        want("rel2_full", S_FULL, 1);
        want("rel2_cnt", S_COUNT, 16);
        check_sb();
        next_edge();
        want("rel3_full", S_FULL, 0);
        want("rel3_cnt", S_COUNT, 12);
        want("rel3_af", S_AFULL, 0);
        check_sb();

        // Reset in the middle of a burst
        bus.wr_en = 1'b1;
        next_edge();
        want("burst_addr1", S_ADDR, 1);
        want("burst_cnt1", S_COUNT, 13);
        check_sb();
        next_edge();
        want("burst_addr2", S_ADDR, 2);
        want("burst_cnt2", S_COUNT, 14);
        want("burst_af", S_AFULL, 1);
        check_sb();
        rst_n           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.rd_ptr_gray = '0;
        #1;
        want_zero("midrst");
        check_sb();
        next_edge();
        want_zero("midrst_hold");
        check_sb();
        rst_n     = 1'b1;
        bus.wr_en = 1'b1;
        #1;
        want("post_addr", S_ADDR, 0);
        want("post_acc", S_ACCEPT, 1);
        check_sb();
        next_edge();
        want("post_addr1", S_ADDR, 1);
        want("post_cnt", S_COUNT, 1);
        want("post_wgray", S_WGRAY, 1);
        check_sb();

        // Preload to 4 entries, then track the reader 4 behind across the wrap
        for (int unsigned i = 2; i <= 4; i++) begin
            next_edge();
            want("pre_cnt", S_COUNT, i);
            check_sb();
        end
        w = 4;
        for (int unsigned k = 0; k < 36; k++) begin
            bus.wr_en = 1'b1;
            next_edge();
            want("wrap_cnt_w", S_COUNT, 5);
            want("wrap_full_w", S_FULL, 0);
            want("wrap_addr", S_ADDR, (w + 1) % 16);
            want("wrap_wgray", S_WGRAY, 32'(gray(w + 1)));
            check_sb();
            bus.wr_en       = 1'b0;
            bus.rd_ptr_gray = gray(w + 1 - 4);
            w++;
            next_edge();
            want("wrap_cnt_s1", S_COUNT, 5);
            check_sb();
            next_edge();
            want("wrap_cnt_s2", S_COUNT, 5);
            check_sb();
            next_edge();
            want("wrap_cnt_s3", S_COUNT, 4);
            want("wrap_full_s3", S_FULL, 0);
            check_sb();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 4, sets the FIFO address width; the depth is 2^ADDR_SIZE entries.
REQ-002 Parameter ALMOST_FULL_THRESH, default 14, sets the occupancy at or above which almost_full asserts; legal range 1..2^ADDR_SIZE.
REQ-003 Port clk, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port wr_en, input, 1 bit: write request from the producer.
REQ-006 Port rd_ptr_gray, input, ADDR_SIZE+1 bits: Gray-coded read pointer from the read clock domain, treated as asynchronous.
REQ-007 Port wr_addr, output, ADDR_SIZE bits: write address to the FIFO memory.
REQ-008 Port wr_ptr_gray, output, ADDR_SIZE+1 bits: registered Gray-coded write pointer, sent to the read domain.
REQ-009 Port wr_accept, output, 1 bit: write-enable qualifier to the memory, combinational, equal to wr_en AND NOT full.
REQ-010 Port full, output, 1 bit: registered full flag.
REQ-011 Port almost_full, output, 1 bit: registered flag, set when occupancy >= ALMOST_FULL_THRESH.
REQ-012 Port wr_count, output, ADDR_SIZE+1 bits: registered occupancy as seen from the write domain, range 0..2^ADDR_SIZE.
REQ-013 Port overflow, output, 1 bit: one-cycle registered pulse flagging a write attempted while full.

Function
REQ-014 An internal binary pointer wbin, ADDR_SIZE+1 bits, shall become wbin_next = wbin + wr_accept on every clk edge and wrap modulo 2^(ADDR_SIZE+1).
REQ-015 wr_addr shall equal wbin[ADDR_SIZE-1:0], combinationally from the register.
REQ-016 wr_ptr_gray shall register (wbin_next >> 1) XOR wbin_next, so the Gray pointer changes in the same cycle as wbin.
REQ-017 rd_ptr_gray shall pass through a two-flop synchronizer; its output rq2 shall be used for all comparisons.
REQ-018 On every edge, full shall register (Gray(wbin_next) == {~rq2[A:A-1], rq2[A-2:0]}), where A = ADDR_SIZE; the 2^ADDR_SIZE-th accepted write therefore sets full on that same edge.
REQ-019 On every edge, wr_count shall register (wbin_next - gray2bin(rq2)) modulo 2^(ADDR_SIZE+1).
REQ-020 On every edge, almost_full shall register (that wr_count value >= ALMOST_FULL_THRESH).
REQ-021 On every edge, overflow shall register (wr_en AND full); while full, wbin and wr_ptr_gray shall stay unchanged.
REQ-022 full and wr_count are pessimistic: after rd_ptr_gray advances, full deasserts at the third clk edge (two synchronizer edges plus the flag register), never earlier.
REQ-023 A write request and a read-pointer advance in the same cycle shall both be counted; no event is dropped.

Reset
REQ-024 While rst_n is low, wbin, both synchronizer flops, wr_ptr_gray, wr_count, full, almost_full and overflow shall be 0, asynchronously.
REQ-025 A reset during operation shall abandon all pointer state; the first write after rst_n deasserts shall go to wr_addr 0.

Structure
REQ-026 A shared package shall hold the default ADDR_SIZE and functions bin2gray and gray2bin, which the read-side pointer block reuses.
REQ-027 The two-flop synchronizer shall be a separate module, sync_2ff, parameterised by WIDTH, with an active-low asynchronous reset, instantiated once.

Verification
REQ-028 Reset check: assert rst_n=0 mid-burst -> all outputs read 0 immediately, and the next write after release uses wr_addr 0.
REQ-029 Fill check: rd_ptr_gray=0, 16 consecutive writes -> wr_addr steps 0..15 then 0; full=1 after the 16th edge; wr_ptr_gray=5'b11000; wr_count=16.
REQ-030 Overflow check: wr_en=1 while full -> wr_accept=0, overflow is high for exactly one cycle, pointers are unchanged.
REQ-031 Release check: from full, set rd_ptr_gray=5'b00110 (binary 4) -> full=0 and wr_count=12 at the third edge, with full still 1 at edges one and two.
REQ-032 Almost-full check: rd_ptr_gray=0, write 13 then 14 entries -> almost_full=0 at wr_count 13 and 1 at 14.
REQ-033 Wrap check: 40 writes with rd_ptr_gray tracking the write pointer 4 entries behind -> wbin wraps 31->0 with no spurious full, and wr_count stays at 4 or 5.
